// File: rtl/mem_access_ctrl.sv
// Load/store unit front end: turns one pipeline memory operation into a single
// aligned 64-bit memory request. It also extracts and extends load results.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        we_mem,
  input  logic        re_mem,
  input  logic [2:0]  memop,
  input  logic [63:0] addr,
  input  logic [63:0] mem_wdata,
  output logic        req_ready,
  output logic        mem_req_valid,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_addr,
  output logic [7:0]  mem_req_wmask,
  output logic [63:0] mem_req_wdata,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata,
  output logic        done_valid,
  output logic [63:0] load_data,
  output logic        err_misalign,
  output logic        err_timeout
);

  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_W  = 3'd2;
  localparam logic [2:0] MEM_D  = 3'd3;
  localparam logic [2:0] MEM_UB = 3'd4;
  localparam logic [2:0] MEM_UH = 3'd5;
  localparam logic [2:0] MEM_UW = 3'd6;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t state, next_state;

  logic             accept;
  logic             in_misalign;
  logic [7:0]       in_wmask;
  logic             resp_timeout;
  logic [CNT_W-1:0] resp_cnt;

  logic [63:0] addr_q;
  logic [2:0]  off_q;
  logic [2:0]  memop_q;
  logic        we_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic        misalign_q;
  logic        timeout_q;
  logic [63:0] load_q;

  function automatic logic [63:0] extract_load(input logic [2:0]  op,
                                               input logic [2:0]  off,
                                               input logic [63:0] word);
    logic [63:0] sh;
    sh = word >> {off, 3'b000};
    case (op)
      MEM_B:   extract_load = {{56{sh[7]}}, sh[7:0]};
      MEM_H:   extract_load = {{48{sh[15]}}, sh[15:0]};
      MEM_W:   extract_load = {{32{sh[31]}}, sh[31:0]};
      MEM_UB:  extract_load = {56'd0, sh[7:0]};
      MEM_UH:  extract_load = {48'd0, sh[15:0]};
      MEM_UW:  extract_load = {32'd0, sh[31:0]};
      MEM_D:   extract_load = sh;
      default: extract_load = '0;
    endcase
  endfunction

  assign accept       = (state == IDLE) && req_valid && (we_mem || re_mem);
  assign resp_timeout = (resp_cnt == CNT_LAST);

  // Unknown codes and unsigned store widths have no byte mask, so they are
  // rejected the same way as a misaligned address.
  always_comb begin
    in_misalign = 1'b0;
    in_wmask    = '0;
    case (memop)
      MEM_B, MEM_UB: begin
        in_misalign = 1'b0;
        in_wmask    = 8'h01 << addr[2:0];
      end
      MEM_H, MEM_UH: begin
        in_misalign = addr[0];
        in_wmask    = 8'h03 << addr[2:0];
      end
      MEM_W, MEM_UW: begin
        in_misalign = |addr[1:0];
        in_wmask    = 8'h0F << addr[2:0];
      end
      MEM_D: begin
        in_misalign = |addr[2:0];
        in_wmask    = 8'hFF;
      end
      default: in_misalign = 1'b1;
    endcase
    if (we_mem && (memop == MEM_UB || memop == MEM_UH || memop == MEM_UW))
      in_misalign = 1'b1;
    if (!we_mem || in_misalign)
      in_wmask = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = in_misalign ? DONE : REQ;
      REQ:  if (mem_req_ready) next_state = RESP;
      RESP: if (mem_resp_valid || resp_timeout) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // load_q only changes on entry to DONE, so the last result stays visible
  // until the next operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      off_q      <= '0;
      memop_q    <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      load_q     <= '0;
      resp_cnt   <= '0;
    end else begin
      if (accept) begin
        addr_q     <= {addr[63:3], 3'b000};
        off_q      <= addr[2:0];
        memop_q    <= memop;
        we_q       <= we_mem;
        wdata_q    <= mem_wdata;
        wmask_q    <= in_wmask;
        misalign_q <= in_misalign;
        timeout_q  <= 1'b0;
      end
      if (state == RESP) resp_cnt <= resp_cnt + 1'b1;
      else               resp_cnt <= '0;
      if (state == RESP && !mem_resp_valid && resp_timeout)
        timeout_q <= 1'b1;
      if (next_state == DONE && state != DONE)
        load_q <= (state == RESP && mem_resp_valid && !we_q) ?
                  extract_load(memop_q, off_q, mem_rdata) : '0;
    end
  end

  always_comb begin
    req_ready     = (state == IDLE);
    mem_req_valid = (state == REQ);
    done_valid    = (state == DONE);
    err_misalign  = (state == DONE) && misalign_q;
    err_timeout   = (state == DONE) && timeout_q;
  end

  assign mem_req_wen   = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wmask = wmask_q;
  assign mem_req_wdata = wdata_q;
  assign load_data     = load_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases with literal expectations, then
// random traffic checked every cycle against a timestamp-based reference model.
module tb_mem_access_ctrl;

  localparam int TO = 4;
  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_W  = 3'd2;
  localparam logic [2:0] MEM_D  = 3'd3;
  localparam logic [2:0] MEM_UH = 3'd5;

  logic        clk = 1'b0;
  logic        rst, req_valid, we_mem, re_mem;
  logic [2:0]  memop;
  logic [63:0] addr, mem_wdata, mem_rdata;
  logic        mem_req_ready, mem_resp_valid;
  logic        req_ready, mem_req_valid, mem_req_wen, done_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, load_data;
  logic [7:0]  mem_req_wmask;
  logic        err_misalign, err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .we_mem(we_mem), .re_mem(re_mem),
    .memop(memop), .addr(addr), .mem_wdata(mem_wdata), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .done_valid(done_valid), .load_data(load_data),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge, then returns mid-cycle.
  task automatic applyStimulus(input logic r, input logic rv, input logic w, input logic re,
                               input logic [2:0] op, input logic [63:0] a, input logic [63:0] wd,
                               input logic rdy, input logic rsp, input logic [63:0] rd);
    @(posedge clk);
    #1;
    rst = r; req_valid = rv; we_mem = w; re_mem = re; memop = op; addr = a;
    mem_wdata = wd; mem_req_ready = rdy; mem_resp_valid = rsp; mem_rdata = rd;
    @(negedge clk);
  endtask

  task automatic quiet(input logic rdy, input logic rsp, input logic [63:0] rd);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, rdy, rsp, rd);
  endtask

  // Reference model: operation sizes in bytes and byte arithmetic.
  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      3'd3:       return 8;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_misaligned(input logic [2:0] op, input logic [63:0] a, input logic w);
    int sz;
    sz = op_size(op);
    if (sz == 0) return 1'b1;
    if (w && op >= 3'd4) return 1'b1;
    return (int'(a[2:0]) % sz) != 0;
  endfunction

  function automatic logic [7:0] model_mask(input logic [2:0] op, input logic [63:0] a, input logic w);
    int sz;
    sz = op_size(op);
    if (!w || sz == 0) return 8'h00;
    return 8'(((1 << sz) - 1) << int'(a[2:0]));
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] op, input int off, input logic [63:0] rd);
    int sz;
    logic [63:0] v, keep;
    sz = op_size(op);
    v = rd >> (8 * off);
    if (sz < 8) begin
      keep = (64'd1 << (8 * sz)) - 64'd1;
      v = v & keep;
      if (op <= 3'd2 && v[8*sz-1]) v = v | ~keep;
    end
    return v;
  endfunction

  int          cyc = 0;
  bit          armed = 1'b0, live = 1'b0, m_we, m_mis, m_to;
  int          t_gnt = -1, t_done = -1, m_off;
  logic [2:0]  m_op;
  logic [7:0]  m_mask;
  logic [63:0] m_addr, m_wdata;
  logic [63:0] pend_load = '0, shown_load = '0;

  // Compare process: mid-cycle check of all outputs, then advance the model
  // with the inputs the next rising edge will sample.
  initial begin
    bit exp_req, exp_done;
    forever begin
      @(negedge clk);
      cyc++;
      if (armed) begin
        if (live && t_done == cyc) shown_load = pend_load;
        exp_req  = live && !m_mis && t_gnt < 0 && t_done < 0;
        exp_done = live && t_done == cyc;
        checkOutput("mon.req_ready", req_ready, !live);
        checkOutput("mon.mem_req_valid", mem_req_valid, exp_req);
        if (exp_req) begin
          checkOutput("mon.mem_req_addr", mem_req_addr, m_addr);
          checkOutput("mon.mem_req_wen", mem_req_wen, m_we);
          checkOutput("mon.mem_req_wmask", mem_req_wmask, m_mask);
          checkOutput("mon.mem_req_wdata", mem_req_wdata, m_wdata);
        end
        checkOutput("mon.done_valid", done_valid, exp_done);
        checkOutput("mon.err_misalign", err_misalign, exp_done && m_mis);
        checkOutput("mon.err_timeout", err_timeout, exp_done && m_to);
        checkOutput("mon.load_data", load_data, shown_load);
      end
      if (rst) begin
        armed = 1'b1; live = 1'b0; t_gnt = -1; t_done = -1; shown_load = '0; m_to = 1'b0;
      end else if (!armed) begin
        live = 1'b0;
      end else if (!live) begin
        if (req_valid && (we_mem || re_mem)) begin
          live = 1'b1; m_we = we_mem; m_op = memop; m_off = int'(addr[2:0]);
          m_mis = model_misaligned(memop, addr, we_mem); m_to = 1'b0;
          m_addr = addr & ~64'd7; m_mask = model_mask(memop, addr, we_mem);
          m_wdata = mem_wdata; t_gnt = -1; t_done = -1;
          if (m_mis) begin t_done = cyc + 1; pend_load = '0; end
        end
      end else if (t_done == cyc) begin
        live = 1'b0;
      end else if (t_done < 0) begin
        if (t_gnt < 0) begin
          if (mem_req_ready) t_gnt = cyc;
        end else if (mem_resp_valid) begin
          t_done = cyc + 1;
          pend_load = m_we ? 64'd0 : model_load(m_op, m_off, mem_rdata);
        end else if (cyc - t_gnt == TO) begin
          t_done = cyc + 1; m_to = 1'b1; pend_load = '0;
        end
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [63:0] a;
    logic        w;
    rst = 1'b1; req_valid = 1'b0; we_mem = 1'b0; re_mem = 1'b0; memop = '0; addr = '0;
    mem_wdata = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    quiet(0, 0, 0);
    checkOutput("reset.req_ready", req_ready, 1);
    checkOutput("reset.mem_req_valid", mem_req_valid, 0);
    checkOutput("reset.mem_req_wen", mem_req_wen, 0);
    checkOutput("reset.mem_req_addr", mem_req_addr, 0);
    checkOutput("reset.mem_req_wmask", mem_req_wmask, 0);
    checkOutput("reset.mem_req_wdata", mem_req_wdata, 0);
    checkOutput("reset.done_valid", done_valid, 0);
    checkOutput("reset.load_data", load_data, 0);
    checkOutput("reset.err_misalign", err_misalign, 0);
    checkOutput("reset.err_timeout", err_timeout, 0);

    // Store byte with immediate handshakes
    applyStimulus(0, 1, 1, 0, MEM_B, 64'h1003, 64'h0000_0000_AB00_0000, 1, 1, 0);
    checkOutput("sb.req_ready", req_ready, 1);
    quiet(1, 1, 0);
    checkOutput("sb.mem_req_valid", mem_req_valid, 1);
    checkOutput("sb.mem_req_addr", mem_req_addr, 64'h1000);
    checkOutput("sb.mem_req_wmask", mem_req_wmask, 8'h08);
    checkOutput("sb.mem_req_wen", mem_req_wen, 1);
    checkOutput("sb.mem_req_wdata", mem_req_wdata, 64'h0000_0000_AB00_0000);
    quiet(1, 1, 0);
    checkOutput("sb.done_early", done_valid, 0);
    quiet(1, 1, 0);
    checkOutput("sb.done_valid", done_valid, 1);
    checkOutput("sb.err_misalign", err_misalign, 0);
    checkOutput("sb.load_data", load_data, 0);

    // Signed and unsigned halfword loads from the top lane
    applyStimulus(0, 1, 0, 1, MEM_H, 64'h2006, 0, 1, 1, 64'h8123_0000_0000_0000);
    repeat (3) quiet(1, 1, 64'h8123_0000_0000_0000);
    checkOutput("lh.done_valid", done_valid, 1);
    checkOutput("lh.load_data", load_data, 64'hFFFF_FFFF_FFFF_8123);
    quiet(0, 0, 0);
    checkOutput("lh.load_held", load_data, 64'hFFFF_FFFF_FFFF_8123);
    applyStimulus(0, 1, 0, 1, MEM_UH, 64'h2006, 0, 1, 1, 64'h8123_0000_0000_0000);
    repeat (3) quiet(1, 1, 64'h8123_0000_0000_0000);
    checkOutput("lhu.load_data", load_data, 64'h0000_0000_0000_8123);

    // Reset in the middle of the response wait, followed by a late response
    applyStimulus(0, 1, 0, 1, MEM_D, 64'h2000, 0, 1, 0, 0);
    quiet(1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("rstmid.in_resp", req_ready, 0);
    quiet(1, 1, 64'h1234);
    checkOutput("rstmid.req_ready", req_ready, 1);
    checkOutput("rstmid.done_valid", done_valid, 0);
    checkOutput("rstmid.load_cleared", load_data, 0);
    checkOutput("rstmid.mem_req_addr", mem_req_addr, 0);
    quiet(1, 1, 64'h1234);
    checkOutput("rstmid.no_done", done_valid, 0);

    // Misaligned word load
    applyStimulus(0, 1, 0, 1, MEM_W, 64'h3002, 0, 1, 1, 0);
    quiet(1, 1, 0);
    checkOutput("lw_mis.mem_req_valid", mem_req_valid, 0);
    checkOutput("lw_mis.done_valid", done_valid, 1);
    checkOutput("lw_mis.err_misalign", err_misalign, 1);
    quiet(1, 1, 0);
    checkOutput("lw_mis.req_ready", req_ready, 1);

    // Memory holds off the request for five cycles
    applyStimulus(0, 1, 1, 0, MEM_D, 64'h4000, 64'h1122_3344_5566_7788, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      quiet(0, 0, 0);
      checkOutput("stall.mem_req_valid", mem_req_valid, 1);
      checkOutput("stall.req_ready", req_ready, 0);
      checkOutput("stall.mem_req_addr", mem_req_addr, 64'h4000);
      checkOutput("stall.mem_req_wmask", mem_req_wmask, 8'hFF);
      checkOutput("stall.mem_req_wdata", mem_req_wdata, 64'h1122_3344_5566_7788);
    end
    quiet(1, 1, 0);
    quiet(1, 1, 0);
    checkOutput("stall.done_early", done_valid, 0);
    quiet(1, 1, 0);
    checkOutput("stall.done_valid", done_valid, 1);

    // Response never arrives
    applyStimulus(0, 1, 0, 1, MEM_W, 64'h5004, 0, 1, 0, 0);
    quiet(1, 0, 0);
    for (int i = 0; i < TO; i++) begin
      quiet(1, 0, 0);
      checkOutput("timeout.wait", done_valid, 0);
    end
    quiet(1, 0, 0);
    checkOutput("timeout.done_valid", done_valid, 1);
    checkOutput("timeout.err_timeout", err_timeout, 1);
    checkOutput("timeout.load_data", load_data, 0);
    quiet(1, 0, 0);
    checkOutput("timeout.req_ready", req_ready, 1);

    // Random traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      w  = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      if (w && op >= 3'd4 && op <= 3'd6) op = op - 3'd4;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
      applyStimulus(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 2) == 0), w,
                    1'($urandom_range(0, 1)), op, a, {$urandom, $urandom},
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                    {$urandom, $urandom});
    end
    quiet(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255; maximum cycles spent in RESP before the operation aborts.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  pipeline presents a memory operation.
REQ-005 we_mem / re_mem  input  1 each  store / load select; both high is illegal and is treated as a store.
REQ-006 memop  input  3  width/sign code from the core package: MEM_B, MEM_H, MEM_W, MEM_D, MEM_UB, MEM_UH, MEM_UW.
REQ-007 addr  input  64  byte address.
REQ-008 mem_wdata  input  64  store data, already shifted into byte lane addr[2:0].
REQ-009 req_ready  output  1  high only in IDLE; the pipeline must stall while it is low.
REQ-010 mem_req_valid, mem_req_wen  output  1 each  memory request strobe and write flag.
REQ-011 mem_req_addr  output  64  {addr[63:3], 3'b0}.
REQ-012 mem_req_wmask  output  8  byte enables; all zero for loads.
REQ-013 mem_req_wdata  output  64  registered copy of mem_wdata.
REQ-014 mem_req_ready, mem_resp_valid  input  1 each  memory handshakes.
REQ-015 mem_rdata  input  64  aligned 64-bit read word.
REQ-016 done_valid  output  1  one-cycle completion pulse.
REQ-017 load_data  output  64  extracted and extended load result.
REQ-018 err_misalign, err_timeout  output  1 each  one-cycle error pulses, coincident with done_valid.

Function
REQ-019 FSM states: IDLE, REQ, RESP, DONE; encoding is free.
REQ-020 IDLE: on req_valid with (we_mem|re_mem), capture addr, memop, wdata and we into registers.
- Aligned request: go to REQ.
- Misaligned request: go to DONE with the misalign flag set.
REQ-021 Misaligned means: H/UH with addr[0]!=0; W/UW with addr[1:0]!=0; D with addr[2:0]!=0; B/UB never.
REQ-022 REQ: mem_req_valid=1; address, wen, wmask and wdata are held stable until mem_req_ready=1 is sampled, then go to RESP.
REQ-023 RESP: a cycle counter starts at 0 and increments each cycle.
- mem_resp_valid=1: capture mem_rdata, go to DONE.
- Counter reaches TIMEOUT_CYCLES-1 without a response: go to DONE with the timeout flag set.
REQ-024 DONE: for one cycle, done_valid=1 plus any error flag; then return to IDLE.
REQ-025 Minimum latency from acceptance in IDLE to done_valid is 3 cycles (mem_req_ready and mem_resp_valid each high on first sample).
REQ-026 wmask per memop: B=8'h01<<addr[2:0]; H=8'h03<<addr[2:0]; W=8'h0F<<addr[2:0]; D=8'hFF; any other code gives 0 and no request is issued (treated as misaligned).
REQ-027 load_data: shift the captured word right by 8*addr[2:0], truncate to the width, then sign-extend (B/H/W) or zero-extend (UB/UH/UW/D).
REQ-028 load_data is held stable from DONE until the next DONE.
REQ-029 load_data is zero after a store, error or timeout.
REQ-030 mem_resp_valid outside RESP is ignored.
REQ-031 mem_req_ready outside REQ is ignored.
REQ-032 Inputs arriving while req_ready=0 are ignored, not queued.
REQ-033 req_valid with neither we_mem nor re_mem is ignored (no state change).

Reset
REQ-034 rst=1 at any rising edge forces IDLE and clears the counter and all captured registers, including in the middle of an operation.
REQ-035 Output values under reset: req_ready=1; mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_wdata, mem_req_addr, done_valid, load_data, err_misalign, err_timeout all 0.
REQ-036 No done_valid is produced for an operation aborted by reset.

Verification
REQ-037 Store SB: addr=0x1003, wdata=0x00000000AB000000, ready and resp immediate -> mem_req_addr=0x1000, wmask=8'h08, done_valid 3 cycles after acceptance.
REQ-038 Load LH: addr=0x2006, mem_rdata=0x8123_0000_0000_0000 -> load_data=0xFFFF_FFFF_FFFF_8123; same case with LHU -> 0x0000_0000_0000_8123.
REQ-039 LW at addr=0x3002 -> no mem_req_valid; done_valid and err_misalign high together on the cycle after acceptance.
REQ-040 mem_req_ready held low 5 cycles -> mem_req_valid and all request fields stable for those 5 cycles, req_ready=0 throughout.
REQ-041 TIMEOUT_CYCLES=4 with mem_resp_valid never asserted -> err_timeout and done_valid pulse after 4 RESP cycles, then IDLE.
REQ-042 rst pulsed while in RESP -> next cycle IDLE with req_ready=1; a late mem_resp_valid is ignored and no done_valid is produced.
